zkbdmus_seq: RTL and testbench

- Packet sequencer that sits between the slave-SPI byte stream from the AVR and the keyboard/mouse/joystick port-data registers.
- Assembles one input snapshot: 5 key-matrix bytes, mouse X, mouse Y, buttons/wheel, Kempston.
- Commits the snapshot atomically at a frame boundary.
- Drives the register strobes one entry per cycle and only for entries whose value changed since the last commit, so Z80 port reads never see a half-updated keyboard matrix.

---
 rtl/zkbdmus_pkg.sv | 30 +++
 rtl/zkbdmus_seq_if.sv | 33 +++
 rtl/zkbdmus_rxpkt.sv | 43 ++++
 rtl/zkbdmus_seq.sv | 188 ++++++++++++++++++
 tb/tb_zkbdmus_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/zkbdmus_pkg.sv
// Shared definitions for the keyboard/mouse packet sequencer: entry map,
// FSM encoding and the packet payload type.
package zkbdmus_pkg;

    localparam int NENT_MAX = 9;

    localparam logic [3:0] IDX_KBD0 = 4'd0;
    localparam logic [3:0] IDX_KBD1 = 4'd1;
    localparam logic [3:0] IDX_KBD2 = 4'd2;
    localparam logic [3:0] IDX_KBD3 = 4'd3;
    localparam logic [3:0] IDX_KBD4 = 4'd4;
    localparam logic [3:0] IDX_MX   = 4'd5;
    localparam logic [3:0] IDX_MY   = 4'd6;
    localparam logic [3:0] IDX_BTN  = 4'd7;
    localparam logic [3:0] IDX_KJ   = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    typedef logic [NENT_MAX-1:0][7:0] payload_t;

    // The Kempston byte is the optional last entry of the packet.
    function automatic logic [3:0] entry_count(input bit kj_en);
        return kj_en ? 4'd9 : 4'd8;
    endfunction

endpackage

// File: rtl/zkbdmus_seq_if.sv
// Byte-stream input and port-data register strobe bundle of the sequencer.
interface zkbdmus_seq_if;

    logic       spi_stb;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       commit_req;
    logic       hold;

    logic [7:0] kbd_in;
    logic [2:0] kbd_in_sel;
    logic       kbd_stb;
    logic [7:0] mus_in;
    logic       mus_xstb;
    logic       mus_ystb;
    logic       mus_btnstb;
    logic       kj_stb;
    logic       busy;
    logic       overrun;

    modport master (
        output spi_stb, spi_start, spi_data, commit_req, hold,
        input  kbd_in, kbd_in_sel, kbd_stb, mus_in, mus_xstb, mus_ystb,
               mus_btnstb, kj_stb, busy, overrun
    );

    modport slave (
        input  spi_stb, spi_start, spi_data, commit_req, hold,
        output kbd_in, kbd_in_sel, kbd_stb, mus_in, mus_xstb, mus_ystb,
               mus_btnstb, kj_stb, busy, overrun
    );

endinterface

// File: rtl/zkbdmus_rxpkt.sv
// Packet receiver: collects SPI bytes into the rx buffer and pulses pkt_done
// for one cycle while the buffer holds a complete packet.
module zkbdmus_rxpkt
    import zkbdmus_pkg::*;
#(
    parameter logic [3:0] NENT = 4'd9
) (
    input  logic     fclk,
    input  logic     rst,
    input  logic     spi_stb,
    input  logic     spi_start,
    input  logic [7:0] spi_data,
    output logic     pkt_done,
    output payload_t pkt_data
);

    logic [3:0] cnt;

    // A start byte always restarts at entry 0; cnt == 0 or NENT drops bytes
    // until the next start. pkt_data is stable during the done cycle because
    // any new start byte lands one edge later.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            pkt_data <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (spi_stb) begin
                if (spi_start) begin
                    pkt_data[0] <= spi_data;
                    cnt         <= 4'd1;
                end else if (cnt != 4'd0 && cnt < NENT) begin
                    pkt_data[cnt] <= spi_data;
                    cnt           <= cnt + 4'd1;
                    if (cnt == NENT - 4'd1)
                        pkt_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/zkbdmus_seq.sv
// Keyboard/mouse snapshot sequencer: buffers a received packet and, at a frame
// boundary, strobes only the changed entries into the port-data registers.
module zkbdmus_seq
    import zkbdmus_pkg::*;
#(
    parameter bit AUTO_COMMIT = 1'b0,
    parameter bit KJ_EN       = 1'b1
) (
    input  logic          fclk,
    input  logic          rst,
    zkbdmus_seq_if.slave  bus
);

    localparam logic [3:0] NENT = entry_count(KJ_EN);
    localparam logic [3:0] LAST = NENT - 4'd1;

    seq_state_t state, state_nx;
    logic [3:0] idx, idx_nx;

    payload_t pkt, pend, committed;
    logic     pkt_done;
    logic [NENT_MAX-1:0] dirty;
    logic     valid, pending, commit_latch, overrun_q;
    logic     start_walk, walk_step, walk_end;

    logic [7:0] kbd_in_q, kbd_in_nx, mus_in_q, mus_in_nx;
    logic [2:0] sel_q, sel_nx;
    logic       kbd_stb_q, kbd_stb_nx;
    logic       xstb_q, xstb_nx, ystb_q, ystb_nx;
    logic       btnstb_q, btnstb_nx, kjstb_q, kjstb_nx;
    logic       busy_q;

    zkbdmus_rxpkt #(.NENT(NENT)) u_rx (
        .fclk      (fclk),
        .rst       (rst),
        .spi_stb   (bus.spi_stb),
        .spi_start (bus.spi_start),
        .spi_data  (bus.spi_data),
        .pkt_done  (pkt_done),
        .pkt_data  (pkt)
    );

    // Snapshot storage. A packet finishing during a walk would tear the
    // snapshot being written out, so it is dropped and flagged instead.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            pend         <= '0;
            committed    <= '0;
            dirty        <= '0;
            valid        <= 1'b0;
            pending      <= 1'b0;
            commit_latch <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (pkt_done) begin
                if (state == RUN) begin
                    overrun_q <= 1'b1;
                end else begin
                    pend    <= pkt;
                    pending <= 1'b1;
                    for (int k = 0; k < NENT_MAX; k++)
                        dirty[k] <= (pkt[k] != committed[k]) || !valid;
                end
            end
            if (walk_end) begin
                committed <= pend;
                valid     <= 1'b1;
                pending   <= 1'b0;
            end
            if (start_walk)
                commit_latch <= 1'b0;
            else if (state == ARMED && bus.commit_req && bus.hold)
                commit_latch <= 1'b1;
        end
    end

    // FSM and strobe register; busy follows the state one cycle late so it
    // lines up with the registered strobes.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 4'd0;
            kbd_in_q  <= 8'd0;
            sel_q     <= 3'd0;
            mus_in_q  <= 8'd0;
            kbd_stb_q <= 1'b0;
            xstb_q    <= 1'b0;
            ystb_q    <= 1'b0;
            btnstb_q  <= 1'b0;
            kjstb_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            kbd_in_q  <= kbd_in_nx;
            sel_q     <= sel_nx;
            mus_in_q  <= mus_in_nx;
            kbd_stb_q <= kbd_stb_nx;
            xstb_q    <= xstb_nx;
            ystb_q    <= ystb_nx;
            btnstb_q  <= btnstb_nx;
            kjstb_q   <= kjstb_nx;
            busy_q    <= (state == RUN);
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        start_walk = 1'b0;
        walk_step  = 1'b0;
        walk_end   = 1'b0;
        kbd_in_nx  = kbd_in_q;
        sel_nx     = sel_q;
        mus_in_nx  = mus_in_q;
        kbd_stb_nx = 1'b0;
        xstb_nx    = 1'b0;
        ystb_nx    = 1'b0;
        btnstb_nx  = 1'b0;
        kjstb_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (pending || pkt_done)
                    state_nx = ARMED;
            end
            ARMED: begin
                if ((bus.commit_req || commit_latch || AUTO_COMMIT) && !bus.hold) begin
                    state_nx   = RUN;
                    idx_nx     = 4'd0;
                    start_walk = 1'b1;
                end
            end
            RUN: begin
                if (!bus.hold) begin
                    walk_step = 1'b1;
                    if (idx == LAST) begin
                        walk_end = 1'b1;
                        state_nx = IDLE;
                        idx_nx   = 4'd0;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (walk_step && dirty[idx]) begin
            case (idx)
                IDX_KBD0, IDX_KBD1, IDX_KBD2, IDX_KBD3, IDX_KBD4: begin
                    kbd_stb_nx = 1'b1;
                    kbd_in_nx  = pend[idx];
                    sel_nx     = idx[2:0];
                end
                IDX_MX: begin
                    xstb_nx   = 1'b1;
                    mus_in_nx = pend[idx];
                end
                IDX_MY: begin
                    ystb_nx   = 1'b1;
                    mus_in_nx = pend[idx];
                end
                IDX_BTN: begin
                    btnstb_nx = 1'b1;
                    mus_in_nx = pend[idx];
                end
                IDX_KJ: begin
                    kjstb_nx  = KJ_EN;
                    mus_in_nx = pend[idx];
                end
                default: ;
            endcase
        end
    end

    assign bus.kbd_in     = kbd_in_q;
    assign bus.kbd_in_sel = sel_q;
    assign bus.kbd_stb    = kbd_stb_q;
    assign bus.mus_in     = mus_in_q;
    assign bus.mus_xstb   = xstb_q;
    assign bus.mus_ystb   = ystb_q;
    assign bus.mus_btnstb = btnstb_q;
    assign bus.kj_stb     = kjstb_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_zkbdmus_seq.sv
// Directed bench for zkbdmus_seq: a default instance (manual commit, Kempston
// on) and an AUTO_COMMIT/no-Kempston instance share clock and reset.
module tb_zkbdmus_seq;

    logic fclk = 1'b0;
    logic rst;

    always #5 fclk = ~fclk;

    zkbdmus_seq_if bus_m ();
    zkbdmus_seq_if bus_a ();

    zkbdmus_seq dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus_m.slave)
    );

    zkbdmus_seq #(.AUTO_COMMIT(1'b1), .KJ_EN(1'b0)) dut_auto (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus_a.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] cur_pkt [0:8];
    logic [8:0] cur_mask;

    logic [7:0] m_kbd [2];
    logic [2:0] m_sel [2];
    logic [7:0] m_mus [2];

    logic kj_seen_a = 1'b0;

    always @(posedge fclk)
        if (bus_a.kj_stb === 1'b1)
            kj_seen_a <= 1'b1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // Packs every output of one instance into a word: {stb,sel,kbd,x,y,btn,kj,mus,busy}.
    function automatic logic [31:0] obsWord(input int which);
        if (which == 0)
            return {7'd0, bus_m.kbd_stb, bus_m.kbd_in_sel, bus_m.kbd_in,
                    bus_m.mus_xstb, bus_m.mus_ystb, bus_m.mus_btnstb, bus_m.kj_stb,
                    bus_m.mus_in, bus_m.busy};
        else
            return {7'd0, bus_a.kbd_stb, bus_a.kbd_in_sel, bus_a.kbd_in,
                    bus_a.mus_xstb, bus_a.mus_ystb, bus_a.mus_btnstb, bus_a.kj_stb,
                    bus_a.mus_in, bus_a.busy};
    endfunction

    task automatic expWord(input int which, input int k, input bit fire, input bit busy,
                           output logic [31:0] w);
        logic kb, x, y, b, j;
        kb = 1'b0; x = 1'b0; y = 1'b0; b = 1'b0; j = 1'b0;
        if (fire) begin
            if (k < 5) begin
                m_kbd[which] = cur_pkt[k];
                m_sel[which] = 3'(k);
                kb = 1'b1;
            end else begin
                m_mus[which] = cur_pkt[k];
                case (k)
                    5: x = 1'b1;
                    6: y = 1'b1;
                    7: b = 1'b1;
                    default: j = 1'b1;
                endcase
            end
        end
        w = {7'd0, kb, m_sel[which], m_kbd[which], x, y, b, j, m_mus[which], busy};
    endtask

    task automatic applyStimulus(input int which, input bit start, input logic [7:0] data);
        if (which == 0) begin
            bus_m.spi_stb = 1'b1; bus_m.spi_start = start; bus_m.spi_data = data;
        end else begin
            bus_a.spi_stb = 1'b1; bus_a.spi_start = start; bus_a.spi_data = data;
        end
        tick();
        bus_m.spi_stb = 1'b0; bus_m.spi_start = 1'b0;
        bus_a.spi_stb = 1'b0; bus_a.spi_start = 1'b0;
    endtask

    task automatic sendPacket(input int which, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(which, i == 0, cur_pkt[i]);
    endtask

    task automatic pulseCommit();
        bus_m.commit_req = 1'b1;
        tick();
        bus_m.commit_req = 1'b0;
    endtask

    // Called one tick after the commit edge; optional hold stalls entry hold_idx.
    task automatic walkCheck(input int which, input int n, input int hold_idx,
                             input int hold_len, input string tag);
        logic [31:0] w;
        int k, held;
        bit h;
        k = 0;
        held = 0;
        while (k < n) begin
            if (k == hold_idx && held < hold_len) begin
                bus_m.hold = 1'b1; h = 1'b1; held++;
            end else begin
                bus_m.hold = 1'b0; h = 1'b0;
            end
            tick();
            if (h) begin
                expWord(which, k, 1'b0, 1'b1, w);
                checkOutput($sformatf("%s hold%0d", tag, held), obsWord(which), w);
            end else begin
                expWord(which, k, cur_mask[k], 1'b1, w);
                checkOutput($sformatf("%s e%0d", tag, k), obsWord(which), w);
                k++;
            end
        end
        bus_m.hold = 1'b0;
        tick();
        expWord(which, 0, 1'b0, 1'b0, w);
        checkOutput($sformatf("%s end", tag), obsWord(which), w);
    endtask

    initial begin
        logic [31:0] w;
        bus_m.spi_stb = 0; bus_m.spi_start = 0; bus_m.spi_data = 0;
        bus_m.commit_req = 0; bus_m.hold = 0;
        bus_a.spi_stb = 0; bus_a.spi_start = 0; bus_a.spi_data = 0;
        bus_a.commit_req = 0; bus_a.hold = 0;
        for (int i = 0; i < 2; i++) begin
            m_kbd[i] = 8'd0; m_sel[i] = 3'd0; m_mus[i] = 8'd0;
        end
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        checkOutput("reset outputs", obsWord(0), 32'd0);
        checkOutput("reset overrun", {31'd0, bus_m.overrun}, 32'd0);
        checkOutput("reset auto outputs", obsWord(1), 32'd0);

        // First packet after reset: every entry is rewritten.
        cur_pkt = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h55, 8'hAA, 8'h07, 8'h1F};
        cur_mask = 9'h1FF;
        sendPacket(0, 9);
        tick(); tick();
        pulseCommit();
        expWord(0, 0, 1'b0, 1'b0, w);
        checkOutput("full commit edge", obsWord(0), w);
        walkCheck(0, 9, -1, 0, "full");

        // Only X changes; commit requested under hold is latched until hold drops.
        cur_pkt[5] = 8'h56;
        cur_mask = 9'b0_0010_0000;
        sendPacket(0, 9);
        tick(); tick();
        bus_m.hold = 1'b1;
        pulseCommit();
        tick();
        expWord(0, 0, 1'b0, 1'b0, w);
        checkOutput("latched commit waits", obsWord(0), w);
        bus_m.hold = 1'b0;
        tick();
        walkCheck(0, 9, -1, 0, "xonly");

        // All entries change; walk stalls three cycles at entry 3.
        cur_pkt = '{8'h11, 8'h12, 8'h14, 8'h18, 8'h20, 8'h65, 8'hBA, 8'h17, 8'h2F};
        cur_mask = 9'h1FF;
        sendPacket(0, 9);
        tick(); tick();
        pulseCommit();
        walkCheck(0, 9, 3, 3, "hold");

        // Packet completing at the commit edge lands during RUN and is dropped.
        cur_pkt = '{8'h21, 8'h12, 8'h24, 8'h18, 8'h30, 8'h65, 8'hCA, 8'h17, 8'h3F};
        cur_mask = 9'b1_0101_0101;
        checkOutput("overrun clear", {31'd0, bus_m.overrun}, 32'd0);
        sendPacket(0, 9);
        tick(); tick();
        for (int i = 0; i < 8; i++)
            applyStimulus(0, i == 0, 8'hEE);
        bus_m.commit_req = 1'b1;
        bus_m.spi_stb = 1'b1; bus_m.spi_start = 1'b0; bus_m.spi_data = 8'hEE;
        tick();
        bus_m.commit_req = 1'b0;
        bus_m.spi_stb = 1'b0;
        walkCheck(0, 9, -1, 0, "ovr");
        checkOutput("overrun set", {31'd0, bus_m.overrun}, 32'd1);

        // Nothing pending: a commit in IDLE must produce no walk.
        pulseCommit();
        for (int i = 0; i < 3; i++) begin
            tick();
            expWord(0, 0, 1'b0, 1'b0, w);
            checkOutput($sformatf("idle commit %0d", i), obsWord(0), w);
        end

        // Partial packet restarted by a new start byte; a trailing 10th byte is ignored.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, i == 0, 8'h99);
        cur_pkt = '{8'h21, 8'h13, 8'h24, 8'h18, 8'h30, 8'h66, 8'hCA, 8'h17, 8'h3F};
        cur_mask = 9'b0_0010_0010;
        sendPacket(0, 9);
        applyStimulus(0, 1'b0, 8'h77);
        tick(); tick();
        pulseCommit();
        walkCheck(0, 9, -1, 0, "restart");
        checkOutput("overrun sticky", {31'd0, bus_m.overrun}, 32'd1);

        // Auto-commit instance: 8-byte packet walks on its own.
        cur_pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h00};
        cur_mask = 9'h0FF;
        sendPacket(1, 8);
        tick(); tick();
        expWord(1, 0, 1'b0, 1'b0, w);
        checkOutput("auto pre-walk", obsWord(1), w);
        walkCheck(1, 8, -1, 0, "auto");
        tick(); tick();
        checkOutput("auto kj never", {31'd0, kj_seen_a}, 32'd0);
        checkOutput("auto overrun", {31'd0, bus_a.overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
